// File: rtl/toggle_handshake_rx.sv
// Receive end of the two-phase toggle handshake.
// The transmitter toggles req_tgl once per word and holds req_data steady
// until ack_tgl answers. This block synchronizes the toggle, captures the
// word, presents it on a valid/ready port, and toggles ack_tgl on consume.
//
// Output handshake: a word transfers on a rising clk edge where out_valid
// and out_ready are both 1. Once raised, out_valid stays 1 and out_data
// stays constant until that transfer (or rst). out_ready may be driven
// freely and may depend on out_valid.
module toggle_handshake_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,   // legal range 2..4
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_tgl,
  input  logic [DATA_W-1:0] req_data,
  output logic              ack_tgl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              proto_err,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              state_dbg    // 0 = IDLE, 1 = HOLD
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] s;
  logic                   req_seen;
  logic                   detect;

  // A new word is pending whenever the synchronized toggle level differs
  // from the last level we accepted.
  assign detect    = s[SYNC_STAGES-1] ^ req_seen;
  assign state_dbg = state;

  // Synchronizer chain for the asynchronous request toggle; s[0] samples req_tgl.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s <= '0;
    end else begin
      s <= {s[SYNC_STAGES-2:0], req_tgl};
    end
  end

  // Capture/hold FSM with all handshake outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_seen  <= 1'b0;
      ack_tgl   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      proto_err <= 1'b0;
      word_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (detect) begin
            out_data  <= req_data;
            req_seen  <= s[SYNC_STAGES-1];
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          // A consume wins over a simultaneous new toggle; that toggle is
          // still pending after this edge and gets captured from IDLE.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            ack_tgl   <= ~ack_tgl;
            word_cnt  <= word_cnt + 1'b1;
            state     <= IDLE;
          end else if (detect) begin
            // Transmitter toggled again before our ack: flag it, keep the word.
            proto_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Bench for toggle_handshake_rx: a default-width instance and a CNT_W=4
// instance share every input, so both see identical traffic.
module tb_toggle_handshake_rx;

  localparam int DATA_W = 8;

  logic              clk;
  logic              rst;
  logic              req_tgl;
  logic [DATA_W-1:0] req_data;
  logic              out_ready;

  logic              ack_tgl,   ack_tgl_s;
  logic              out_valid, out_valid_s;
  logic [DATA_W-1:0] out_data,  out_data_s;
  logic              proto_err, proto_err_s;
  logic [15:0]       word_cnt;
  logic [3:0]        word_cnt_s;
  logic              state_dbg, state_dbg_s;

  logic [DATA_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int consumed = 0;   // words seen transferred since last reset

  toggle_handshake_rx #(.DATA_W(DATA_W), .SYNC_STAGES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_tgl(req_tgl), .req_data(req_data),
    .ack_tgl(ack_tgl), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .proto_err(proto_err), .word_cnt(word_cnt),
    .state_dbg(state_dbg)
  );

  toggle_handshake_rx #(.DATA_W(DATA_W), .SYNC_STAGES(2), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .req_tgl(req_tgl), .req_data(req_data),
    .ack_tgl(ack_tgl_s), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .proto_err(proto_err_s), .word_cnt(word_cnt_s),
    .state_dbg(state_dbg_s)
  );

  // Clock/reset: clk starts high so the first rising edge is at 10 ns.
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard sample on the falling edge: a word seen valid&ready here
  // transfers on the next rising edge.
  task automatic sample();
    logic [DATA_W-1:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {24'h0, out_data}, 32'hffff_ffff);
      end else begin
        e = exp_q.pop_front();
        check("out_data", {24'h0, out_data}, {24'h0, e});
        check("out_data_s", {24'h0, out_data_s}, {24'h0, e});
      end
      consumed++;
    end
  endtask

  // One cycle: sample at negedge, then return 1 ns after the rising edge.
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  // Transmitter driver: present a word and toggle the request.
  task automatic send_word(input logic [DATA_W-1:0] d);
    req_data = d;
    req_tgl  = ~req_tgl;
    exp_q.push_back(d);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!out_valid) check({tag, "_valid_timeout"}, 0, 1);
  endtask

  task automatic wait_consumed(input int target, input string tag);
    int n = 0;
    while (consumed < target && n < 40) begin
      tick();
      n++;
    end
    if (consumed < target) check({tag, "_consume_timeout"}, consumed, target);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_ack"}, {31'h0, ack_tgl}, consumed & 1);
    check({tag, "_cnt"}, {16'h0, word_cnt}, consumed & 16'hffff);
    check({tag, "_cnt_s"}, {28'h0, word_cnt_s}, consumed & 4'hf);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req_tgl = 1'b0;
    exp_q.delete();
    consumed = 0;
    #1;
    check("rst_valid", {31'h0, out_valid}, 0);
    check("rst_ack", {31'h0, ack_tgl}, 0);
    check("rst_cnt", {16'h0, word_cnt}, 0);
    check("rst_cnt_s", {28'h0, word_cnt_s}, 0);
    check("rst_err", {31'h0, proto_err}, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0; req_tgl = 1'b0; req_data = '0; out_ready = 1'b0;

    // Reset asserted at 3 ns: outputs must clear before any clock edge.
    #3 rst = 1'b1;
    #1;
    check("por_valid", {31'h0, out_valid}, 0);
    check("por_data", {24'h0, out_data}, 0);
    check("por_ack", {31'h0, ack_tgl}, 0);
    check("por_err", {31'h0, proto_err}, 0);
    check("por_cnt", {16'h0, word_cnt}, 0);
    check("por_state", {31'h0, state_dbg}, 0);
    #11 rst = 1'b0;   // released at 15 ns, a falling edge
    tick();

    // Single word with exact capture latency.
    send_word(8'hA5);
    tick();
    check("lat_e0_valid", {31'h0, out_valid}, 0);
    tick();
    check("lat_e1_valid", {31'h0, out_valid}, 0);
    tick();
    check("lat_e2_valid", {31'h0, out_valid}, 1);
    check("lat_e2_data", {24'h0, out_data}, 32'hA5);
    check("lat_e2_state", {31'h0, state_dbg}, 1);
    check("lat_ack_idle", {31'h0, ack_tgl}, 0);
    out_ready = 1'b1;
    tick();
    check("single_valid", {31'h0, out_valid}, 0);
    check("single_ack", {31'h0, ack_tgl}, 1);
    check("single_cnt", {16'h0, word_cnt}, 1);
    check("single_consumed", consumed, 1);
    out_ready = 1'b0;

    // Stream of 16 words, transmitter paced by the ack.
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      send_word(i[7:0]);
      wait_consumed(i, "stream");
    end
    check("stream_consumed", consumed, 16);
    check("stream_cnt", {16'h0, word_cnt}, 16);
    check("stream_cnt_s", {28'h0, word_cnt_s}, 0);
    check("stream_ack", {31'h0, ack_tgl}, 0);
    check("stream_err", {31'h0, proto_err}, 0);
    check("stream_q_empty", exp_q.size(), 0);

    // Backpressure: word must stay put for 20 cycles.
    out_ready = 1'b0;
    send_word(8'h3C);
    wait_valid("bp");
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_valid", {31'h0, out_valid}, 1);
      check("bp_data", {24'h0, out_data}, 32'h3C);
      check("bp_ack", {31'h0, ack_tgl}, 0);
    end
    out_ready = 1'b1;
    wait_consumed(17, "bp");
    check_counts("bp");
    out_ready = 1'b0;

    // Violation: second toggle while the first word is held.
    send_word(8'h11);
    wait_valid("viol");
    send_word(8'h22);
    for (int i = 0; i < 4; i++) tick();
    check("viol_err", {31'h0, proto_err}, 1);
    check("viol_err_s", {31'h0, proto_err_s}, 1);
    check("viol_valid", {31'h0, out_valid}, 1);
    check("viol_data", {24'h0, out_data}, 32'h11);
    out_ready = 1'b1;
    wait_consumed(19, "viol");
    check_counts("viol");
    check("viol_q_empty", exp_q.size(), 0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("viol_err_sticky", {31'h0, proto_err}, 1);
    check("viol_idle", {31'h0, out_valid}, 0);

    // Wrap: 17 words through the 4-bit counter instance.
    do_reset();
    check("post_rst_err", {31'h0, proto_err}, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      send_word(8'($urandom_range(0, 255)));
      wait_consumed(i + 1, "wrap");
    end
    check("wrap_cnt_s", {28'h0, word_cnt_s}, 1);
    check("wrap_cnt", {16'h0, word_cnt}, 17);
    check("wrap_ack", {31'h0, ack_tgl}, 1);

    // Reset while a word is held: dropped with no ack.
    out_ready = 1'b0;
    send_word(8'h5A);
    wait_valid("hold_rst");
    check("hold_rst_pre_valid", {31'h0, out_valid}, 1);
    rst     = 1'b1;
    req_tgl = 1'b0;
    exp_q.delete();
    consumed = 0;
    #1;
    check("hold_rst_valid", {31'h0, out_valid}, 0);
    check("hold_rst_cnt", {16'h0, word_cnt}, 0);
    check("hold_rst_cnt_s", {28'h0, word_cnt_s}, 0);
    check("hold_rst_ack", {31'h0, ack_tgl}, 0);
    tick();
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("after_rst_ack", {31'h0, ack_tgl}, 0);
    check("after_rst_valid", {31'h0, out_valid}, 0);
    check("after_rst_consumed", consumed, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
